operand_sequencer: RTL and testbench

//   Parametrised operand/operator entry sequencer for the DE-10 Lite calculator.

---
 rtl/calc_pkg.sv | 11 +
 rtl/btn_edge.sv | 14 +
 rtl/operand_sequencer.sv | 89 ++++++++
 tb/tb_operand_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: calculator FSM state encodings shared by the entry, display and ALU blocks.
package calc_pkg;
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] S_NUM1 = 3'd1;
  localparam logic [STATE_W-1:0] S_OPER = 3'd2;
  localparam logic [STATE_W-1:0] S_NUM2 = 3'd3;
  localparam logic [STATE_W-1:0] S_CALC = 3'd4;
  localparam logic [STATE_W-1:0] S_SHOW = 3'd5;
  localparam logic [STATE_W-1:0] S_ERR  = 3'd6;
endpackage

// File: rtl/btn_edge.sv
// btn_edge: synchronises an active-low button and emits one pulse per press.
module btn_edge (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic evt
);
  logic [2:0] sync;
  // two synchroniser flops plus one history flop; idle level is high
  always_ff @(posedge clock or posedge reset)
    if (reset) sync <= '1;
    else sync <= {sync[1:0], btn_n};
  assign evt = sync[2] & ~sync[1];
endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer: operand/operator entry FSM with ALU handshake, timeout and display drive.
module operand_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int OP_BITS   = 2,
  parameter int RES_WIDTH = 2 * WIDTH,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push_n,
  input  logic                 back_n,
  input  logic [WIDTH-1:0]     num,
  input  logic [OP_BITS-1:0]   op,
  input  logic                 mode,
  input  logic [RES_WIDTH-1:0] result,
  input  logic                 result_valid,
  output logic [WIDTH-1:0]     operand1,
  output logic [WIDTH-1:0]     operand2,
  output logic [OP_BITS:0]     md_operator,
  output logic                 start,
  output logic [STATE_W-1:0]   state,
  output logic                 show_res,
  output logic                 error,
  output logic [RES_WIDTH-1:0] bin
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  logic push_evt, back_evt;
  logic [STATE_W-1:0] nxt;
  logic [TW-1:0] timer, timer_d;
  logic [RES_WIDTH-1:0] res_q, res_d, bin_d;
  logic [WIDTH-1:0] op1_d, op2_d;
  logic [OP_BITS:0] md_d;
  btn_edge u_push (.clock(clock), .reset(reset), .btn_n(push_n), .evt(push_evt));
  btn_edge u_back (.clock(clock), .reset(reset), .btn_n(back_n), .evt(back_evt));
  // registered outputs are loaded from values computed for the state being entered
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE:        nxt = push_evt ? S_NUM1 : S_IDLE;
      S_NUM1:        nxt = back_evt ? S_IDLE : push_evt ? S_OPER : S_NUM1;
      S_OPER:        nxt = back_evt ? S_NUM1 : push_evt ? S_NUM2 : S_OPER;
      S_NUM2:        nxt = back_evt ? S_OPER : push_evt ? S_CALC : S_NUM2;
      S_CALC:        nxt = result_valid ? S_SHOW : (timer == T_LAST) ? S_ERR : S_CALC;
      S_SHOW, S_ERR: nxt = back_evt ? S_NUM2 : push_evt ? S_IDLE : state;
      default:       nxt = S_IDLE;
    endcase
    op1_d   = (nxt == S_IDLE) ? '0 : (nxt == S_NUM1) ? num : operand1;
    op2_d   = (nxt == S_IDLE) ? '0 : (nxt == S_NUM2) ? num : operand2;
    md_d    = (nxt == S_IDLE) ? '0 : (nxt == S_OPER) ? {mode, op} : md_operator;
    res_d   = (nxt == S_IDLE) ? '0 : (state == S_CALC && result_valid) ? result : res_q;
    timer_d = (state == S_CALC && nxt == S_CALC) ? timer + 1'b1 : '0;
    bin_d   = '0;
    case (nxt)
      S_NUM1:         bin_d = RES_WIDTH'(op1_d);
      S_OPER:         bin_d = RES_WIDTH'(md_d);
      S_NUM2, S_CALC: bin_d = RES_WIDTH'(op2_d);
      S_SHOW:         bin_d = res_d;
      S_ERR:          bin_d = '1;
      default:        bin_d = '0;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state       <= S_IDLE;
      operand1    <= '0;
      operand2    <= '0;
      md_operator <= '0;
      start       <= 1'b0;
      show_res    <= 1'b0;
      error       <= 1'b0;
      bin         <= '0;
      res_q       <= '0;
      timer       <= '0;
    end else begin
      state       <= nxt;
      operand1    <= op1_d;
      operand2    <= op2_d;
      md_operator <= md_d;
      start       <= (state == S_NUM2) && (nxt == S_CALC);
      show_res    <= nxt == S_SHOW;
      error       <= nxt == S_ERR;
      bin         <= bin_d;
      res_q       <= res_d;
      timer       <= timer_d;
    end
endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: table-driven directed check of the calculator entry sequencer.
module tb_operand_sequencer;
  logic clock = 1'b0, reset, push_n, back_n, mode, result_valid;
  logic [3:0] num;
  logic [1:0] op;
  logic [7:0] result;
  logic [3:0] operand1, operand2;
  logic [2:0] md_operator, state;
  logic start, show_res, error;
  logic [7:0] bin;
  int vectors = 0, miscompares = 0, start_cnt = 0;

  localparam int A_NONE = 0, A_PUSH = 1, A_BACK = 2, A_BOTH = 3, A_RES = 4, A_WAIT = 5, A_HOLD = 6;

  typedef struct {
    int act;
    logic [3:0] num;
    logic [1:0] op;
    logic mode;
    logic [7:0] res;
    logic [2:0] st;
    logic [3:0] o1, o2;
    logic [2:0] md;
    logic [7:0] bin;
    logic sh, er;
    int starts;
  } vec_t;
  vec_t v[24];

  operand_sequencer #(.WIDTH(4), .OP_BITS(2), .RES_WIDTH(8), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .push_n(push_n), .back_n(back_n), .num(num), .op(op),
    .mode(mode), .result(result), .result_valid(result_valid), .operand1(operand1),
    .operand2(operand2), .md_operator(md_operator), .start(start), .state(state),
    .show_res(show_res), .error(error), .bin(bin));

  always #5 clock = ~clock;
  always @(negedge clock) if (start) start_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic p, input logic b, input int hold);
    push_n = ~p;
    back_n = ~b;
    tick(hold);
    push_n = 1'b1;
    back_n = 1'b1;
    tick(4);
  endtask

  task automatic pulse_result(input logic [7:0] r);
    result = r;
    result_valid = 1'b1;
    tick(1);
    result_valid = 1'b0;
    tick(1);
  endtask

  task automatic launch();
    push_n = 1'b0;
    tick(1);
    push_n = 1'b1;
    for (int i = 0; i < 10 && !start; i++) tick(1);
    chk("launch_start_seen", 32'(start), 32'd1);
  endtask

  initial begin
    v[0]  = '{A_NONE, 4'h0, 2'd0, 1'b0, 8'h00, 3'd0, 4'h0, 4'h0, 3'd0, 8'h00, 1'b0, 1'b0, 0};
    v[1]  = '{A_HOLD, 4'h7, 2'd0, 1'b0, 8'h00, 3'd1, 4'h7, 4'h0, 3'd0, 8'h07, 1'b0, 1'b0, 0};
    v[2]  = '{A_PUSH, 4'h7, 2'd2, 1'b1, 8'h00, 3'd2, 4'h7, 4'h0, 3'd6, 8'h06, 1'b0, 1'b0, 0};
    v[3]  = '{A_BACK, 4'hA, 2'd2, 1'b1, 8'h00, 3'd1, 4'hA, 4'h0, 3'd6, 8'h0A, 1'b0, 1'b0, 0};
    v[4]  = '{A_PUSH, 4'hA, 2'd2, 1'b1, 8'h00, 3'd2, 4'hA, 4'h0, 3'd6, 8'h06, 1'b0, 1'b0, 0};
    v[5]  = '{A_PUSH, 4'h3, 2'd2, 1'b1, 8'h00, 3'd3, 4'hA, 4'h3, 3'd6, 8'h03, 1'b0, 1'b0, 0};
    v[6]  = '{A_RES,  4'h3, 2'd2, 1'b1, 8'h55, 3'd3, 4'hA, 4'h3, 3'd6, 8'h03, 1'b0, 1'b0, 0};
    v[7]  = '{A_BOTH, 4'h3, 2'd2, 1'b1, 8'h00, 3'd2, 4'hA, 4'h3, 3'd6, 8'h06, 1'b0, 1'b0, 0};
    v[8]  = '{A_PUSH, 4'h3, 2'd2, 1'b1, 8'h00, 3'd3, 4'hA, 4'h3, 3'd6, 8'h03, 1'b0, 1'b0, 0};
    v[9]  = '{A_PUSH, 4'h3, 2'd2, 1'b1, 8'h00, 3'd4, 4'hA, 4'h3, 3'd6, 8'h03, 1'b0, 1'b0, 1};
    v[10] = '{A_RES,  4'h3, 2'd2, 1'b1, 8'h15, 3'd5, 4'hA, 4'h3, 3'd6, 8'h15, 1'b1, 1'b0, 1};
    v[11] = '{A_PUSH, 4'h3, 2'd2, 1'b1, 8'h00, 3'd0, 4'h0, 4'h0, 3'd0, 8'h00, 1'b0, 1'b0, 1};
    v[12] = '{A_PUSH, 4'h2, 2'd2, 1'b1, 8'h00, 3'd1, 4'h2, 4'h0, 3'd0, 8'h02, 1'b0, 1'b0, 1};
    v[13] = '{A_PUSH, 4'h2, 2'd1, 1'b0, 8'h00, 3'd2, 4'h2, 4'h0, 3'd1, 8'h01, 1'b0, 1'b0, 1};
    v[14] = '{A_PUSH, 4'h5, 2'd1, 1'b0, 8'h00, 3'd3, 4'h2, 4'h5, 3'd1, 8'h05, 1'b0, 1'b0, 1};
    v[15] = '{A_PUSH, 4'h5, 2'd1, 1'b0, 8'h00, 3'd4, 4'h2, 4'h5, 3'd1, 8'h05, 1'b0, 1'b0, 2};
    v[16] = '{A_WAIT, 4'h5, 2'd1, 1'b0, 8'h00, 3'd6, 4'h2, 4'h5, 3'd1, 8'hFF, 1'b0, 1'b1, 2};
    v[17] = '{A_BACK, 4'h6, 2'd1, 1'b0, 8'h00, 3'd3, 4'h2, 4'h6, 3'd1, 8'h06, 1'b0, 1'b0, 2};
    v[18] = '{A_PUSH, 4'h6, 2'd1, 1'b0, 8'h00, 3'd4, 4'h2, 4'h6, 3'd1, 8'h06, 1'b0, 1'b0, 3};
    v[19] = '{A_RES,  4'h6, 2'd1, 1'b0, 8'h2A, 3'd5, 4'h2, 4'h6, 3'd1, 8'h2A, 1'b1, 1'b0, 3};
    v[20] = '{A_BACK, 4'h6, 2'd1, 1'b0, 8'h00, 3'd3, 4'h2, 4'h6, 3'd1, 8'h06, 1'b0, 1'b0, 3};
    v[21] = '{A_PUSH, 4'h6, 2'd1, 1'b0, 8'h00, 3'd4, 4'h2, 4'h6, 3'd1, 8'h06, 1'b0, 1'b0, 4};
    v[22] = '{A_WAIT, 4'h6, 2'd1, 1'b0, 8'h00, 3'd6, 4'h2, 4'h6, 3'd1, 8'hFF, 1'b0, 1'b1, 4};
    v[23] = '{A_PUSH, 4'h6, 2'd1, 1'b0, 8'h00, 3'd0, 4'h0, 4'h0, 3'd0, 8'h00, 1'b0, 1'b0, 4};

    reset = 1'b1; push_n = 1'b1; back_n = 1'b1; num = '0; op = '0; mode = 1'b0;
    result = '0; result_valid = 1'b0;
    tick(2);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_bin", 32'(bin), 32'd0);
    chk("reset_flags", 32'({start, show_res, error}), 32'd0);
    reset = 1'b0;
    tick(1);

    for (int i = 0; i < 24; i++) begin
      num = v[i].num; op = v[i].op; mode = v[i].mode;
      case (v[i].act)
        A_PUSH: press(1'b1, 1'b0, 1);
        A_BACK: press(1'b0, 1'b1, 1);
        A_BOTH: press(1'b1, 1'b1, 1);
        A_HOLD: press(1'b1, 1'b0, 10);
        A_RES:  pulse_result(v[i].res);
        A_WAIT: tick(20);
        default: tick(1);
      endcase
      vectors++;
      chk($sformatf("v%0d_state", i), 32'(state), 32'(v[i].st));
      chk($sformatf("v%0d_operand1", i), 32'(operand1), 32'(v[i].o1));
      chk($sformatf("v%0d_operand2", i), 32'(operand2), 32'(v[i].o2));
      chk($sformatf("v%0d_md_operator", i), 32'(md_operator), 32'(v[i].md));
      chk($sformatf("v%0d_bin", i), 32'(bin), 32'(v[i].bin));
      chk($sformatf("v%0d_show_res", i), 32'(show_res), 32'(v[i].sh));
      chk($sformatf("v%0d_error", i), 32'(error), 32'(v[i].er));
      chk($sformatf("v%0d_start_count", i), 32'(start_cnt), 32'(v[i].starts));
    end

    // result arriving in the very last S_CALC cycle beats the timeout
    num = 4'h1;
    press(1'b1, 1'b0, 1);
    press(1'b1, 1'b0, 1);
    press(1'b1, 1'b0, 1);
    launch();
    tick(14);
    vectors++;
    chk("last_cycle_still_calc", 32'(state), 32'd4);
    result = 8'h99;
    result_valid = 1'b1;
    tick(1);
    result_valid = 1'b0;
    chk("last_cycle_state", 32'(state), 32'd5);
    chk("last_cycle_bin", 32'(bin), 32'h99);
    chk("last_cycle_error", 32'(error), 32'd0);

    // reset in S_CALC drops start asynchronously and blocks a later result
    press(1'b1, 1'b0, 1);
    press(1'b1, 1'b0, 1);
    press(1'b1, 1'b0, 1);
    press(1'b1, 1'b0, 1);
    launch();
    #1 reset = 1'b1;
    #1;
    vectors++;
    chk("async_reset_start", 32'(start), 32'd0);
    chk("async_reset_state", 32'(state), 32'd0);
    tick(1);
    reset = 1'b0;
    pulse_result(8'h77);
    tick(2);
    chk("post_reset_state", 32'(state), 32'd0);
    chk("post_reset_show", 32'(show_res), 32'd0);
    chk("post_reset_bin", 32'(bin), 32'd0);
    chk("post_reset_operand1", 32'(operand1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
